rr_arb_mux_2x1: RTL and testbench

RR_ARB_MUX_2X1 -- requirements
Module: rr_arb_mux_2x1

---
 rtl/rr_arb_mux_2x1.sv | 74 +++++++
 tb/tb_rr_arb_mux_2x1.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/rr_arb_mux_2x1.sv
// Two-input round-robin arbiter feeding a one-beat registered output slot.
// Also keeps saturating per-source counts of accepted beats.
module rr_arb_mux_2x1 #(
   parameter int WIDTH = 8,
   parameter int CNTW  = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] a_data,
   input  logic             a_valid,
   output logic             a_ready,
   input  logic [WIDTH-1:0] b_data,
   input  logic             b_valid,
   output logic             b_ready,
   output logic [WIDTH-1:0] y,
   output logic             y_valid,
   input  logic             y_ready,
   output logic             y_sel,
   output logic [CNTW-1:0]  a_cnt,
   output logic [CNTW-1:0]  b_cnt
);

   localparam logic [CNTW-1:0] CNT_MAX = '1;

   logic prio;     // 1 = A wins a tie, 0 = B wins a tie
   logic load;
   logic grant_a;
   logic grant_b;
   logic take_a;
   logic take_b;

   // The slot can take a new beat when it is empty or is being drained this cycle.
   assign load    = ~y_valid | y_ready;
   assign grant_a = a_valid & (~b_valid | prio);
   assign grant_b = b_valid & (~a_valid | ~prio);
   assign a_ready = load & grant_a;
   assign b_ready = load & grant_b;
   assign take_a  = a_valid & a_ready;
   assign take_b  = b_valid & b_ready;

   // NOTE: non-blocking assignments keep every register sampling pre-edge values,
   // so ordering between the statements below cannot change the result.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         y       <= '0;
         y_sel   <= 1'b0;
         y_valid <= 1'b0;
         prio    <= 1'b1;
      end else if (take_a) begin
         y       <= a_data;
         y_sel   <= 1'b1;
         y_valid <= 1'b1;
         prio    <= 1'b0;
      end else if (take_b) begin
         y       <= b_data;
         y_sel   <= 1'b0;
         y_valid <= 1'b1;
         prio    <= 1'b1;
      end else if (y_ready) begin
         y_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_cnt <= '0;
         b_cnt <= '0;
      end else begin
         if (take_a && a_cnt != CNT_MAX) a_cnt <= a_cnt + 1'b1;
         if (take_b && b_cnt != CNT_MAX) b_cnt <= b_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_rr_arb_mux_2x1.sv
// Self-checking bench: directed vector table, async-reset and saturation
// sequences, then random traffic against a one-slot queue model.
module tb_rr_arb_mux_2x1;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] a_data = '0, b_data = '0, y;
   logic       a_valid = 1'b0, b_valid = 1'b0, y_ready = 1'b0;
   logic       a_ready, b_ready, y_valid, y_sel;
   logic [7:0] a_cnt, b_cnt;

   // Narrow-counter instance for the saturation test.
   logic [7:0] c_a_data = '0, c_b_data = '0, c_y;
   logic       c_a_valid = 1'b0, c_b_valid = 1'b0, c_y_ready = 1'b0;
   logic       c_a_ready, c_b_ready, c_y_valid, c_y_sel;
   logic [1:0] c_a_cnt, c_b_cnt;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   rr_arb_mux_2x1 #(.WIDTH(8), .CNTW(8)) dut (
      .clk(clk), .rst(rst),
      .a_data(a_data), .a_valid(a_valid), .a_ready(a_ready),
      .b_data(b_data), .b_valid(b_valid), .b_ready(b_ready),
      .y(y), .y_valid(y_valid), .y_ready(y_ready), .y_sel(y_sel),
      .a_cnt(a_cnt), .b_cnt(b_cnt)
   );

   rr_arb_mux_2x1 #(.WIDTH(8), .CNTW(2)) dut_sat (
      .clk(clk), .rst(rst),
      .a_data(c_a_data), .a_valid(c_a_valid), .a_ready(c_a_ready),
      .b_data(c_b_data), .b_valid(c_b_valid), .b_ready(c_b_ready),
      .y(c_y), .y_valid(c_y_valid), .y_ready(c_y_ready), .y_sel(c_y_sel),
      .a_cnt(c_a_cnt), .b_cnt(c_b_cnt)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   typedef struct {
      logic       av, bv, yr;
      logic [7:0] ad, bd;
      logic       ear, ebr, eyv, esel;
      logic [7:0] ey, eac, ebc;
   } vec_t;

   typedef struct {
      logic [7:0] data;
      logic       sel;
   } beat_t;

   vec_t  tbl[$];
   beat_t q[$];

   initial begin
      logic       next_is_a;
      logic       room, exp_ar, exp_br;
      int         cnt_a, cnt_b;
      logic [7:0] sat_exp;

      // Reset state, held while rst is high with no clock dependence.
      #2;
      check("rst_y_valid", y_valid, 0);
      check("rst_y", y, 0);
      check("rst_y_sel", y_sel, 0);
      check("rst_a_cnt", a_cnt, 0);
      check("rst_b_cnt", b_cnt, 0);
      #10 rst = 1'b0;          // released between edges
      @(posedge clk); #1;

      //            av bv yr  ad     bd     ar bv yv sel  y      ac     bc
      tbl.push_back('{1, 1, 1, 8'h11, 8'h22, 1, 0, 1, 1, 8'h11, 8'd1, 8'd0});
      tbl.push_back('{1, 1, 1, 8'h11, 8'h22, 0, 1, 1, 0, 8'h22, 8'd1, 8'd1});
      tbl.push_back('{1, 1, 1, 8'h11, 8'h22, 1, 0, 1, 1, 8'h11, 8'd2, 8'd1});
      tbl.push_back('{1, 1, 1, 8'h11, 8'h22, 0, 1, 1, 0, 8'h22, 8'd2, 8'd2});
      tbl.push_back('{0, 1, 1, 8'h00, 8'h33, 0, 1, 1, 0, 8'h33, 8'd2, 8'd3});
      tbl.push_back('{0, 1, 1, 8'h00, 8'h34, 0, 1, 1, 0, 8'h34, 8'd2, 8'd4});
      tbl.push_back('{0, 1, 1, 8'h00, 8'h35, 0, 1, 1, 0, 8'h35, 8'd2, 8'd5});
      tbl.push_back('{1, 1, 1, 8'h44, 8'h55, 1, 0, 1, 1, 8'h44, 8'd3, 8'd5});
      for (int i = 0; i < 4; i++)
         tbl.push_back('{1, 1, 0, 8'h46, 8'h56, 0, 0, 1, 1, 8'h44, 8'd3, 8'd5});
      tbl.push_back('{1, 1, 1, 8'h46, 8'h56, 0, 1, 1, 0, 8'h56, 8'd3, 8'd6});
      tbl.push_back('{0, 0, 0, 8'h00, 8'h00, 0, 0, 1, 0, 8'h56, 8'd3, 8'd6});
      tbl.push_back('{0, 0, 1, 8'h00, 8'h00, 0, 0, 0, 0, 8'h56, 8'd3, 8'd6});
      tbl.push_back('{1, 0, 0, 8'h47, 8'h00, 1, 0, 1, 1, 8'h47, 8'd4, 8'd6});
      tbl.push_back('{0, 1, 0, 8'h00, 8'h57, 0, 0, 1, 1, 8'h47, 8'd4, 8'd6});
      tbl.push_back('{0, 0, 1, 8'h00, 8'h00, 0, 0, 0, 1, 8'h47, 8'd4, 8'd6});
      tbl.push_back('{1, 1, 1, 8'h48, 8'h58, 0, 1, 1, 0, 8'h58, 8'd4, 8'd7});

      foreach (tbl[i]) begin
         a_valid = tbl[i].av; b_valid = tbl[i].bv; y_ready = tbl[i].yr;
         a_data  = tbl[i].ad; b_data  = tbl[i].bd;
         #1;
         check($sformatf("v%0d_a_ready", i), a_ready, tbl[i].ear);
         check($sformatf("v%0d_b_ready", i), b_ready, tbl[i].ebr);
         @(posedge clk); #1;
         check($sformatf("v%0d_y_valid", i), y_valid, tbl[i].eyv);
         check($sformatf("v%0d_y", i), y, tbl[i].ey);
         check($sformatf("v%0d_y_sel", i), y_sel, tbl[i].esel);
         check($sformatf("v%0d_a_cnt", i), a_cnt, tbl[i].eac);
         check($sformatf("v%0d_b_cnt", i), b_cnt, tbl[i].ebc);
      end

      // Async reset while a beat is held and stalled.
      a_valid = 1'b1; b_valid = 1'b1; y_ready = 1'b0;
      a_data = 8'h66; b_data = 8'h77;
      #1;
      check("stall_a_ready", a_ready, 0);
      check("stall_b_ready", b_ready, 0);
      #1 rst = 1'b1;
      #1;
      check("arst_y_valid", y_valid, 0);
      check("arst_y", y, 0);
      check("arst_y_sel", y_sel, 0);
      check("arst_a_cnt", a_cnt, 0);
      check("arst_b_cnt", b_cnt, 0);
      check("arst_a_ready", a_ready, 1);
      check("arst_b_ready", b_ready, 0);
      @(negedge clk) rst = 1'b0;
      @(posedge clk); #1;
      check("post_rst_y", y, 8'h66);
      check("post_rst_y_sel", y_sel, 1);
      check("post_rst_y_valid", y_valid, 1);
      check("post_rst_a_cnt", a_cnt, 1);

      // Random traffic versus a one-entry queue model.
      q.push_back('{8'h66, 1'b1});
      next_is_a = 1'b0;
      cnt_a = 1; cnt_b = 0;
      for (int cyc = 0; cyc < 400; cyc++) begin
         a_valid = ($urandom_range(0, 9) < 6);
         b_valid = ($urandom_range(0, 9) < 6);
         y_ready = ($urandom_range(0, 9) < 6);
         a_data  = 8'($urandom);
         b_data  = 8'($urandom);
         #1;
         room   = (q.size() == 0) || y_ready;
         exp_ar = room && a_valid && (!b_valid || next_is_a);
         exp_br = room && b_valid && (!a_valid || !next_is_a);
         check("rnd_a_ready", a_ready, exp_ar);
         check("rnd_b_ready", b_ready, exp_br);
         check("rnd_y_valid", y_valid, q.size() != 0);
         if (q.size() != 0) begin
            check("rnd_y", y, q[0].data);
            check("rnd_y_sel", y_sel, q[0].sel);
         end
         check("rnd_a_cnt", a_cnt, cnt_a);
         check("rnd_b_cnt", b_cnt, cnt_b);
         if (y_ready && q.size() != 0) void'(q.pop_front());
         if (exp_ar) begin
            q.push_back('{a_data, 1'b1});
            next_is_a = 1'b0;
            cnt_a = (cnt_a < 255) ? cnt_a + 1 : 255;
         end
         if (exp_br) begin
            q.push_back('{b_data, 1'b0});
            next_is_a = 1'b1;
            cnt_b = (cnt_b < 255) ? cnt_b + 1 : 255;
         end
         @(posedge clk); #1;
      end

      // Saturation on the 2-bit counter instance.
      check("sat_start", c_a_cnt, 0);
      c_a_valid = 1'b1; c_y_ready = 1'b1;
      for (int k = 1; k <= 6; k++) begin
         c_a_data = 8'(k);
         @(posedge clk); #1;
         sat_exp = (k < 3) ? 8'(k) : 8'd3;
         check($sformatf("sat_a_cnt_%0d", k), c_a_cnt, sat_exp);
         check($sformatf("sat_y_%0d", k), c_y, k);
      end
      check("sat_b_cnt", c_b_cnt, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
